ov_7670_frame_ctrl: RTL and testbench
=====================================

// Module: ov_7670_frame_ctrl
// PURPOSE
//  Session sequencer for the OV7670 camera path. Kicks ov_7670_init, waits for done,
//  aligns to VSYNC, then gates ov_7670_capture frame-by-frame via cap_en.
//  Schedules a ping-pong frame buffer between capture (writer) and display (reader);
//  drops frames when display still holds the front buffer. Sits beside init/capture in top.
// PARAMETERS
//  INIT_TIMEOUT  50_000_000  clk cycles allowed for init_done after init_start (1 s @50 MHz)
//  VS_TIMEOUT    5_000_000   max clk cycles between VSYNC rises before error (100 ms)
//  NUM_FRAMES    0           frames to capture then stop; 0 = continuous
//  FRAME_CNT_W   16          width of frame_count
// PORTS
//  clk          in   1   system clock (CLOCK_50 at top)
//  reset        in   1   asynchronous, active-high reset
//  cmd_start    in   1   1-cycle request to start a session
//  cmd_stop     in   1   1-cycle request to stop a session
//  init_done    in   1   level from ov_7670_init, already in clk domain
//  vsync_async  in   1   camera VSYNC pin, asynchronous to clk
//  disp_busy    in   1   display is reading rd_buf; swap forbidden while high
//  init_start   out  1   1-cycle pulse to ov_7670_init
//  cap_en       out  1   capture write enable qualifier (changes only at VSYNC rise)
//  wr_buf       out  1   buffer index being written by capture
//  rd_buf       out  1   buffer index owned by display; always ~wr_buf
//  frame_ready  out  1   1-cycle pulse: rd_buf now holds a complete new frame
//  busy         out  1   high in INIT, WAIT_VS, CAPTURE
//  error        out  1   high in ERROR state
//  err_code     out  2   00 none, 01 init timeout, 10 vsync timeout
//  frame_count  out  FRAME_CNT_W  frames completed this session, wraps
//  drop_count   out  8   frames dropped due to disp_busy, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except rd_buf=1; counters and stop-pending cleared.
//  VSYNC: 2-FF synchroniser + edge reg; vs_rise pulse 3 clk after pin rise.
//  States: IDLE -> INIT -> WAIT_VS -> CAPTURE -> IDLE; INIT/WAIT_VS/CAPTURE -> ERROR.
//  IDLE: cmd_start & !cmd_stop -> INIT; clears frame_count, drop_count, err_code.
//   Same-cycle start+stop: stop wins, stay IDLE.
//  ERROR: holds error=1, err_code; cmd_start -> INIT (clears error). cmd_stop ignored.
//  INIT: init_start pulses on the first cycle only; init_done=1 -> WAIT_VS;
//   timer reaching INIT_TIMEOUT -> ERROR, err_code=01. cmd_stop -> IDLE immediately.
//  WAIT_VS: discards partial frame; first vs_rise -> CAPTURE (no frame counted).
//   cmd_stop -> IDLE immediately. Watchdog active (see below).
//  CAPTURE: cap_en=1 (registered; rises cycle after entry, falls cycle after exit).
//   On vs_rise: frame_count+1 (wrap); if !disp_busy: wr_buf/rd_buf swap same edge,
//   frame_ready pulses next cycle; else no swap, drop_count+1 (sat 255).
//   Exit to IDLE on vs_rise if stop pending or (NUM_FRAMES!=0 & new count==NUM_FRAMES);
//   the frame ending at that edge is still counted/swapped.
//   cmd_stop sets stop-pending; does not drop cap_en mid-frame.
//  Watchdog: counts in WAIT_VS/CAPTURE, cleared on entry and each vs_rise;
//   reaching VS_TIMEOUT -> ERROR, err_code=10, cap_en drops next cycle.
//  cmd_start while busy ignored. Buffer indices persist across sessions.
//  Mid-operation reset: async clear to reset values, no init_start emitted.
// STRUCTURE
//  ov_7670_pkg: state_t enum {IDLE,INIT,WAIT_VS,CAPTURE,ERROR}; err_t with ERR_NONE,
//   ERR_INIT_TO, ERR_VS_TO constants.
//  Sub-module ov_7670_sync_edge: 2-FF synchroniser + rising-edge pulse (reused elsewhere).
//  Timers: one shared down-counter sized for max(INIT_TIMEOUT,VS_TIMEOUT).
// TESTING (INIT_TIMEOUT=100, VS_TIMEOUT=200, NUM_FRAMES=0 unless noted)
//  Start, init_done at cycle 20, VSYNC every 50 clk -> one init_start pulse, cap_en after
//   first VSYNC, frame_count=1 after second, frame_ready pulse, wr_buf=1 rd_buf=0.
//  init_done never asserted -> ERROR at cycle ~100, err_code=01; cmd_start recovers.
//  VSYNC stops during CAPTURE -> ERROR after 200 clk, err_code=10, cap_en=0.
//  disp_busy=1 across 3 VSYNC rises -> drop_count=3, no swap, no frame_ready.
//  NUM_FRAMES=4 -> IDLE after 4th counted rise, frame_count=4, busy=0;
//   cmd_stop mid-frame -> cap_en held until next rise, then IDLE.
//  Reset asserted in CAPTURE -> all outputs to reset values same cycle, rd_buf=1.

Source files
------------

// File: rtl/ov_7670_pkg.sv
// Shared types for the OV7670 session sequencer: FSM states, error codes and
// a saturating counter helper.
package ov_7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_VS,
    CAPTURE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_INIT_TO = 2'b01,
    ERR_VS_TO   = 2'b10
  } err_t;

  localparam int DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ov_7670_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a registered
// one-cycle rising-edge pulse (pulse appears on the third clk after the pin rises).
module ov_7670_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic       rise_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      prev_reg <= sync_reg[1];
      rise_reg <= sync_reg[1] & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/ov_7670_frame_ctrl.sv
// Session sequencer for the OV7670 path: starts init, aligns to VSYNC, gates
// capture per frame and ping-pongs the frame buffers with the display.
module ov_7670_frame_ctrl
  import ov_7670_pkg::*;
#(
  parameter int INIT_TIMEOUT = 50_000_000,
  parameter int VS_TIMEOUT   = 5_000_000,
  parameter int NUM_FRAMES   = 0,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   init_done,
  input  logic                   vsync_async,
  input  logic                   disp_busy,
  output logic                   init_start,
  output logic                   cap_en,
  output logic                   wr_buf,
  output logic                   rd_buf,
  output logic                   frame_ready,
  output logic                   busy,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int MAX_TO = (INIT_TIMEOUT > VS_TIMEOUT) ? INIT_TIMEOUT : VS_TIMEOUT;
  localparam int TMR_W  = $clog2(MAX_TO + 1);
  localparam logic [TMR_W-1:0]       INIT_LOAD   = TMR_W'(INIT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]       VS_LOAD     = TMR_W'(VS_TIMEOUT - 1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LIMIT = FRAME_CNT_W'(NUM_FRAMES);

  state_t                 state_reg;
  err_t                   err_reg;
  logic [TMR_W-1:0]       tmr_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [DROP_CNT_W-1:0]  drop_cnt_reg;
  logic                   stop_pend_reg;
  logic                   wr_buf_reg;
  logic                   cap_en_reg;
  logic                   init_start_reg;
  logic                   frame_ready_reg;
  logic                   busy_reg;
  logic                   error_reg;

  logic                   vs_rise;
  logic [FRAME_CNT_W-1:0] frame_cnt_inc;
  logic                   last_frame;

  ov_7670_sync_edge u_vs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (vsync_async),
    .rise  (vs_rise)
  );

  assign frame_cnt_inc = frame_cnt_reg + 1'b1;
  assign last_frame    = (NUM_FRAMES != 0) && (frame_cnt_inc == FRAME_LIMIT);

  // One shared down-counter serves as init timer in INIT and VSYNC watchdog after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      err_reg         <= ERR_NONE;
      tmr_reg         <= '0;
      frame_cnt_reg   <= '0;
      drop_cnt_reg    <= '0;
      stop_pend_reg   <= 1'b0;
      wr_buf_reg      <= 1'b0;
      cap_en_reg      <= 1'b0;
      init_start_reg  <= 1'b0;
      frame_ready_reg <= 1'b0;
      busy_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      init_start_reg  <= 1'b0;
      frame_ready_reg <= 1'b0;
      cap_en_reg      <= (state_reg == CAPTURE);
      case (state_reg)
        IDLE, ERROR: begin
          // In ERROR a stop request is ignored, so start+stop still restarts.
          if (cmd_start && (state_reg == ERROR || !cmd_stop)) begin
            state_reg      <= INIT;
            busy_reg       <= 1'b1;
            error_reg      <= 1'b0;
            err_reg        <= ERR_NONE;
            init_start_reg <= 1'b1;
            tmr_reg        <= INIT_LOAD;
            frame_cnt_reg  <= '0;
            drop_cnt_reg   <= '0;
            stop_pend_reg  <= 1'b0;
          end
        end
        INIT: begin
          if (cmd_stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (init_done) begin
            state_reg <= WAIT_VS;
            tmr_reg   <= VS_LOAD;
          end else if (tmr_reg == '0) begin
            state_reg <= ERROR;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            err_reg   <= ERR_INIT_TO;
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        WAIT_VS: begin
          if (cmd_stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (vs_rise) begin
            state_reg <= CAPTURE;
            tmr_reg   <= VS_LOAD;
          end else if (tmr_reg == '0) begin
            state_reg <= ERROR;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            err_reg   <= ERR_VS_TO;
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        CAPTURE: begin
          if (cmd_stop) stop_pend_reg <= 1'b1;
          if (vs_rise) begin
            // The frame closing at this edge is always counted, even when leaving.
            tmr_reg       <= VS_LOAD;
            frame_cnt_reg <= frame_cnt_inc;
            if (!disp_busy) begin
              wr_buf_reg      <= ~wr_buf_reg;
              frame_ready_reg <= 1'b1;
            end else begin
              drop_cnt_reg <= sat_inc(drop_cnt_reg);
            end
            if (stop_pend_reg || cmd_stop || last_frame) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              stop_pend_reg <= 1'b0;
            end
          end else if (tmr_reg == '0) begin
            state_reg     <= ERROR;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b1;
            err_reg       <= ERR_VS_TO;
            stop_pend_reg <= 1'b0;
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign init_start  = init_start_reg;
  assign cap_en      = cap_en_reg;
  assign wr_buf      = wr_buf_reg;
  assign rd_buf      = ~wr_buf_reg;
  assign frame_ready = frame_ready_reg;
  assign busy        = busy_reg;
  assign error       = error_reg;
  assign err_code    = err_reg;
  assign frame_count = frame_cnt_reg;
  assign drop_count  = drop_cnt_reg;

endmodule

// File: tb/tb_ov_7670_frame_ctrl.sv
// Bench for ov_7670_frame_ctrl: command table, whole-session scenarios with an
// arithmetic frame/drop/buffer model, timeout and reset corner cases.
module tb_ov_7670_frame_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_start = 1'b0, cmd_stop = 1'b0, init_done = 1'b0;
  logic vsync_async = 1'b0, disp_busy = 1'b0;

  logic init_start, cap_en, wr_buf, rd_buf, frame_ready, busy, error;
  logic [1:0] err_code;
  logic [15:0] frame_count;
  logic [7:0] drop_count;

  logic init_start_4, cap_en_4, wr_buf_4, rd_buf_4, frame_ready_4, busy_4, error_4;
  logic [1:0] err_code_4;
  logic [15:0] frame_count_4;
  logic [7:0] drop_count_4;

  int checks = 0;
  int errors = 0;
  int is_cnt = 0;
  int fr_cnt = 0;
  logic exp_wr = 1'b0;

  always #5 clk = ~clk;

  ov_7670_frame_ctrl #(.INIT_TIMEOUT(100), .VS_TIMEOUT(200), .NUM_FRAMES(0), .FRAME_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .init_done(init_done), .vsync_async(vsync_async), .disp_busy(disp_busy),
    .init_start(init_start), .cap_en(cap_en), .wr_buf(wr_buf), .rd_buf(rd_buf),
    .frame_ready(frame_ready), .busy(busy), .error(error), .err_code(err_code),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  ov_7670_frame_ctrl #(.INIT_TIMEOUT(100), .VS_TIMEOUT(200), .NUM_FRAMES(4), .FRAME_CNT_W(16)) dut4 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .init_done(init_done), .vsync_async(vsync_async), .disp_busy(disp_busy),
    .init_start(init_start_4), .cap_en(cap_en_4), .wr_buf(wr_buf_4), .rd_buf(rd_buf_4),
    .frame_ready(frame_ready_4), .busy(busy_4), .error(error_4), .err_code(err_code_4),
    .frame_count(frame_count_4), .drop_count(drop_count_4)
  );

  always @(posedge clk) begin
    if (init_start) is_cnt <= is_cnt + 1;
    if (frame_ready) fr_cnt <= fr_cnt + 1;
  end

  typedef struct {
    logic start, stop, idone;
    logic e_busy, e_istart, e_cap;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: first rise only aligns; every later rise completes a frame, which is
  // either handed to the display (swap + frame_ready) or dropped if it is busy.
  task automatic session(input int n, input int period, input logic [7:0] bmask);
    int drops, swaps, fr0, is0;
    drops = 0;
    swaps = 0;
    fr0 = fr_cnt;
    is0 = is_cnt;
    cmd_start = 1'b1; tick(1); cmd_start = 1'b0;
    tick(19); init_done = 1'b1; tick(5);
    for (int k = 0; k < n; k++) begin
      check("cap_en_before_rise", cap_en, (k > 0));
      check("busy_in_session", busy, 1);
      vsync_async = 1'b1;
      disp_busy = bmask[k];
      if (k > 0) begin
        if (bmask[k]) drops++;
        else swaps++;
      end
      tick(3);
      vsync_async = 1'b0;
      if (k == n - 2) begin
        tick(7);
        cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
        tick(period - 11);
      end else begin
        tick(period - 3);
      end
    end
    exp_wr = exp_wr ^ swaps[0];
    init_done = 1'b0;
    disp_busy = 1'b0;
    check("frame_count", frame_count, n - 1);
    check("drop_count", drop_count, drops);
    check("wr_buf", wr_buf, exp_wr);
    check("rd_buf", rd_buf, !exp_wr);
    check("frame_ready_pulses", fr_cnt - fr0, swaps);
    check("init_start_pulses", is_cnt - is0, 1);
    check("busy_after_stop", busy, 0);
    check("cap_en_after_stop", cap_en, 0);
    check("error_in_session", error, 0);
    $display("session n=%0d period=%0d busy=%b frames=%0d drops=%0d swaps=%0d",
             n, period, bmask, n - 1, drops, swaps);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[10];
    int cyc, is0;

    tbl[0] = '{0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 1, 0, 0};
    tbl[5] = '{1, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 1, 0};
    tbl[8] = '{0, 0, 1, 1, 0, 0};
    tbl[9] = '{0, 1, 1, 0, 0, 0};

    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_init_start", init_start, 0);
    check("rst_cap_en", cap_en, 0);
    check("rst_wr_buf", wr_buf, 0);
    check("rst_rd_buf", rd_buf, 1);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);

    for (int i = 0; i < 10; i++) begin
      cmd_start = tbl[i].start;
      cmd_stop = tbl[i].stop;
      init_done = tbl[i].idone;
      tick(1);
      cmd_start = 1'b0;
      cmd_stop = 1'b0;
      check("vec_busy", busy, tbl[i].e_busy);
      check("vec_init_start", init_start, tbl[i].e_istart);
      check("vec_cap_en", cap_en, tbl[i].e_cap);
      check("vec_error", error, 0);
      $display("vec %0d start=%b stop=%b idone=%b busy=%b init_start=%b",
               i, tbl[i].start, tbl[i].stop, tbl[i].idone, busy, init_start);
    end
    init_done = 1'b0;
    tick(2);

    session(2, 50, 8'b0000_0000);
    session(4, 40, 8'b0000_1110);
    session(6, 30, 8'b0000_0000);
    check("nf4_frame_count", frame_count_4, 4);
    check("nf4_busy", busy_4, 0);
    check("nf4_cap_en", cap_en_4, 0);
    for (int r = 0; r < 4; r++) begin
      int n, p;
      logic [7:0] m;
      n = $urandom_range(8, 3);
      p = $urandom_range(60, 20);
      m = 8'($urandom);
      session(n, p, m);
    end

    // init_done never arrives
    cmd_start = 1'b1; tick(1); cmd_start = 1'b0;
    cyc = 1;
    while (!error && cyc < 150) begin
      tick(1);
      cyc++;
    end
    $display("init timeout after %0d cycles err_code=%0d", cyc, err_code);
    check("init_to_window", (cyc >= 95 && cyc <= 105), 1);
    check("init_to_err_code", err_code, 1);
    check("init_to_busy", busy, 0);
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    check("error_ignores_stop", error, 1);
    cmd_start = 1'b1; tick(1); cmd_start = 1'b0;
    check("recover_error", error, 0);
    check("recover_err_code", err_code, 0);
    check("recover_busy", busy, 1);
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    check("recover_stop", busy, 0);

    // VSYNC disappears mid-capture; display busy so buffers stay put
    disp_busy = 1'b1;
    cmd_start = 1'b1; tick(1); cmd_start = 1'b0;
    tick(19); init_done = 1'b1; tick(5);
    vsync_async = 1'b1; tick(3); vsync_async = 1'b0; tick(37);
    vsync_async = 1'b1; tick(3); vsync_async = 1'b0;
    cyc = 3;
    while (!error && cyc < 300) begin
      tick(1);
      cyc++;
    end
    $display("vsync timeout after %0d cycles err_code=%0d", cyc, err_code);
    check("vs_to_window", (cyc >= 195 && cyc <= 215), 1);
    check("vs_to_err_code", err_code, 2);
    check("vs_to_frame_count", frame_count, 1);
    check("vs_to_drop_count", drop_count, 1);
    tick(1);
    check("vs_to_cap_en", cap_en, 0);
    check("vs_to_busy", busy, 0);
    check("vs_to_wr_buf", wr_buf, exp_wr);
    init_done = 1'b0;
    disp_busy = 1'b0;
    cmd_start = 1'b1; tick(1); cmd_start = 1'b0;
    check("vs_recover_error", error, 0);
    cmd_stop = 1'b1; tick(1); cmd_stop = 1'b0;
    check("vs_recover_stop", busy, 0);

    // Reset while capturing
    cmd_start = 1'b1; tick(1); cmd_start = 1'b0;
    tick(19); init_done = 1'b1; tick(5);
    vsync_async = 1'b1; tick(3); vsync_async = 1'b0; tick(37);
    vsync_async = 1'b1; tick(3); vsync_async = 1'b0; tick(10);
    check("pre_reset_cap_en", cap_en, 1);
    check("pre_reset_wr_buf", wr_buf, !exp_wr);
    reset = 1'b1;
    #1;
    check("mid_reset_cap_en", cap_en, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_wr_buf", wr_buf, 0);
    check("mid_reset_rd_buf", rd_buf, 1);
    check("mid_reset_frame_count", frame_count, 0);
    check("mid_reset_frame_ready", frame_ready, 0);
    tick(2);
    reset = 1'b0;
    init_done = 1'b0;
    exp_wr = 1'b0;
    is0 = is_cnt;
    tick(5);
    check("post_reset_no_init_start", is_cnt - is0, 0);
    check("post_reset_busy", busy, 0);
    $display("reset during capture: wr_buf=%b rd_buf=%b", wr_buf, rd_buf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
